// File: rtl/bp_me_pkg.sv
// Shared types and constants for the memory command arbiter slice.
package bp_me_pkg;

  // One memory message as carried on the command and response channels
  typedef struct packed {
    logic [3:0]  msg_type;
    logic [2:0]  size;
    logic [39:0] addr;
    logic [16:0] payload;
  } bp_cce_mem_msg_s;

  localparam int unsigned cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

  // Width of one per-requester grant counter
  localparam int unsigned bp_grant_cnt_width_lp = 32;

  // Arbiter grant state: free to re-arbitrate, or holding a stalled grant
  typedef enum logic {
    eIDLE   = 1'b0,
    eLOCKED = 1'b1
  } bp_mem_arb_state_e;

  // Requester-id width; a single requester still needs one bit
  function automatic int unsigned bp_req_id_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/bp_mem_order_fifo.sv
// Order FIFO holding the requester id of every command awaiting its response.
// Wrap-around pointers plus an explicit full bit; depth must be a power of 2.
module bp_mem_order_fifo #(
  parameter int unsigned els_p   = 4,
  parameter int unsigned width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               push_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               empty_o,
  output logic               full_o
);

  localparam int unsigned ptr_width_lp = $clog2(els_p);

  logic [ptr_width_lp-1:0] r_wptr;
  logic [ptr_width_lp-1:0] r_rptr;
  logic                    r_full;
  logic [width_p-1:0]      r_mem [els_p];

  logic [ptr_width_lp-1:0] w_wptr_inc;
  logic [ptr_width_lp-1:0] w_rptr_inc;

  assign w_wptr_inc = r_wptr + ptr_width_lp'(1);
  assign w_rptr_inc = r_rptr + ptr_width_lp'(1);

  // Pointer and full-flag update; simultaneous push/pop keeps occupancy
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_full <= 1'b0;
    end else begin
      if (push_i) r_wptr <= w_wptr_inc;
      if (pop_i)  r_rptr <= w_rptr_inc;
      if (push_i && !pop_i) begin
        r_full <= (w_wptr_inc == r_rptr);
      end else if (pop_i && !push_i) begin
        r_full <= 1'b0;
      end
    end
  end

  // Storage write; contents need no reset since the pointers qualify them
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wptr] <= data_i;
  end

  assign data_o  = r_mem[r_rptr];
  assign empty_o = (r_wptr == r_rptr) && !r_full;
  assign full_o  = r_full;

endmodule

// File: rtl/bp_mem_cmd_arbiter.sv
// Round-robin arbiter sharing one memory command port among num_req_p
// requesters, with in-order response routing back to the issuing requester.
// Optional per-requester grant counters when BP_MEM_ARB_PERF_EN is defined.
module bp_mem_cmd_arbiter
  import bp_me_pkg::*;
#(
  parameter int unsigned num_req_p      = 2,
  parameter int unsigned inflight_els_p = 4,
  parameter int unsigned msg_width_p    = cce_mem_msg_width_lp
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p*msg_width_p-1:0] cmd_i,
  input  logic [num_req_p-1:0]             cmd_v_i,
  output logic [num_req_p-1:0]             cmd_ready_o,
  output logic [msg_width_p-1:0]           mem_cmd_o,
  output logic                             mem_cmd_v_o,
  input  logic                             mem_cmd_ready_i,
  input  logic [msg_width_p-1:0]           mem_resp_i,
  input  logic                             mem_resp_v_i,
  output logic                             mem_resp_ready_o,
  output logic [msg_width_p-1:0]           resp_o,
  output logic [num_req_p-1:0]             resp_v_o,
  input  logic [num_req_p-1:0]             resp_ready_i
`ifdef BP_MEM_ARB_PERF_EN
  ,
  output logic [num_req_p*bp_grant_cnt_width_lp-1:0] grant_cnt_o
`endif
);

  localparam int unsigned id_width_lp = bp_req_id_width(num_req_p);

  bp_mem_arb_state_e      r_state;
  bp_mem_arb_state_e      w_state_n;
  logic [id_width_lp-1:0] r_prio_ptr;
  logic [id_width_lp-1:0] r_lock_id;

  logic [id_width_lp-1:0] w_scan_id;
  logic [id_width_lp-1:0] w_rr_id;
  logic                   w_rr_v;
  logic [id_width_lp-1:0] w_sel_id;
  logic                   w_sel_v;
  logic                   w_cmd_xfer;
  logic                   w_resp_xfer;
  logic                   w_can_push;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [id_width_lp-1:0] w_head_id;
  logic [msg_width_p-1:0] w_cmd [num_req_p];

  // Unpack the flat command bus, requester 0 in the LSBs
  for (genvar gi = 0; gi < num_req_p; gi++) begin : g_unpack
    assign w_cmd[gi] = cmd_i[gi*msg_width_p +: msg_width_p];
  end

  // Round-robin scan starting at the current highest-priority requester
  always_comb begin
    w_rr_id   = r_prio_ptr;
    w_rr_v    = 1'b0;
    w_scan_id = '0;
    for (int unsigned k = 0; k < num_req_p; k++) begin
      w_scan_id = id_width_lp'((32'(r_prio_ptr) + k) % num_req_p);
      if (!w_rr_v && cmd_v_i[w_scan_id]) begin
        w_rr_v  = 1'b1;
        w_rr_id = w_scan_id;
      end
    end
  end

  // Response side: the FIFO head owns the response channel
  assign mem_resp_ready_o = !w_fifo_empty && resp_ready_i[w_head_id];
  assign w_resp_xfer      = mem_resp_v_i && mem_resp_ready_o;
  assign resp_o           = mem_resp_i;

  // A full FIFO can still take a push if a response pops in the same cycle
  assign w_can_push = !w_fifo_full || w_resp_xfer;

  // One-hot response valid toward the head owner only
  always_comb begin
    resp_v_o = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      resp_v_o[i] = mem_resp_v_i && !w_fifo_empty && (w_head_id == id_width_lp'(i));
    end
  end

  // Grant FSM next-state and command-side outputs
  always_comb begin
    w_state_n   = r_state;
    w_sel_id    = w_rr_id;
    w_sel_v     = w_rr_v;
    mem_cmd_v_o = 1'b0;
    w_cmd_xfer  = 1'b0;

    if (r_state == eLOCKED) begin
      w_sel_id = r_lock_id;
      w_sel_v  = cmd_v_i[r_lock_id];
    end

    mem_cmd_v_o = w_sel_v && w_can_push;
    w_cmd_xfer  = mem_cmd_v_o && mem_cmd_ready_i;

    case (r_state)
      eIDLE:   if (mem_cmd_v_o && !mem_cmd_ready_i) w_state_n = eLOCKED;
      eLOCKED: if (w_cmd_xfer) w_state_n = eIDLE;
      default: w_state_n = eIDLE;
    endcase
  end

  assign mem_cmd_o = w_cmd[w_sel_id];

  // Accept strobe back to the granted requester on transfer
  always_comb begin
    cmd_ready_o = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      cmd_ready_o[i] = w_cmd_xfer && (w_sel_id == id_width_lp'(i));
    end
  end

  // Grant state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= eIDLE;
    else         r_state <= w_state_n;
  end

  // Capture the stalled requester so the grant holds until it transfers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_lock_id <= '0;
    end else if (r_state == eIDLE && w_state_n == eLOCKED) begin
      r_lock_id <= w_sel_id;
    end
  end

  // Priority moves to the requester after the one that just transferred
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_prio_ptr <= '0;
    end else if (w_cmd_xfer) begin
      r_prio_ptr <= (w_sel_id == id_width_lp'(num_req_p - 1)) ? '0
                                                              : w_sel_id + id_width_lp'(1);
    end
  end

  bp_mem_order_fifo #(
    .els_p   (inflight_els_p),
    .width_p (id_width_lp)
  ) u_order_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (w_sel_id),
    .push_i  (w_cmd_xfer),
    .pop_i   (w_resp_xfer),
    .data_o  (w_head_id),
    .empty_o (w_fifo_empty),
    .full_o  (w_fifo_full)
  );

`ifdef BP_MEM_ARB_PERF_EN
  // Saturating per-requester transfer counters
  for (genvar gc = 0; gc < num_req_p; gc++) begin : g_perf
    logic [bp_grant_cnt_width_lp-1:0] r_cnt;

    // Count accepted commands, holding at the maximum value
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        r_cnt <= '0;
      end else if (cmd_ready_o[gc] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + bp_grant_cnt_width_lp'(1);
      end
    end

    assign grant_cnt_o[gc*bp_grant_cnt_width_lp +: bp_grant_cnt_width_lp] = r_cnt;
  end
`else
  // Performance counters are not built in this configuration.
`endif

`ifndef SYNTHESIS
  // A response with nothing outstanding has no owner to route to
  a_no_orphan_resp: assert property (@(posedge clk_i) disable iff (reset_i)
                                     !(mem_resp_v_i && w_fifo_empty))
    else $error("bp_mem_cmd_arbiter: memory response with no command outstanding");
`endif

endmodule

// File: tb/tb_bp_mem_cmd_arbiter.sv
// Directed table-driven bench for bp_mem_cmd_arbiter (num_req_p=2, inflight_els_p=4).
module tb_bp_mem_cmd_arbiter;
  import bp_me_pkg::*;

  localparam int unsigned N = 2;
  localparam int unsigned W = cce_mem_msg_width_lp;
  localparam logic [W-1:0] CMD0 = W'(64'hA0A0_0000_0000_1000);
  localparam logic [W-1:0] CMD1 = W'(64'hB1B1_0000_0000_2001);
  localparam logic [W-1:0] RESP = W'(64'hC3C3_5A5A_0F0F_7777);

  logic           clk;
  logic           reset_i;
  logic [N*W-1:0] cmd_i;
  logic [N-1:0]   cmd_v_i;
  logic [N-1:0]   cmd_ready_o;
  logic [W-1:0]   mem_cmd_o;
  logic           mem_cmd_v_o;
  logic           mem_cmd_ready_i;
  logic [W-1:0]   mem_resp_i;
  logic           mem_resp_v_i;
  logic           mem_resp_ready_o;
  logic [W-1:0]   resp_o;
  logic [N-1:0]   resp_v_o;
  logic [N-1:0]   resp_ready_i;
`ifdef BP_MEM_ARB_PERF_EN
  logic [N*32-1:0] grant_cnt_o;
`endif

  bp_mem_cmd_arbiter #(
    .num_req_p      (N),
    .inflight_els_p (4),
    .msg_width_p    (W)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .cmd_i            (cmd_i),
    .cmd_v_i          (cmd_v_i),
    .cmd_ready_o      (cmd_ready_o),
    .mem_cmd_o        (mem_cmd_o),
    .mem_cmd_v_o      (mem_cmd_v_o),
    .mem_cmd_ready_i  (mem_cmd_ready_i),
    .mem_resp_i       (mem_resp_i),
    .mem_resp_v_i     (mem_resp_v_i),
    .mem_resp_ready_o (mem_resp_ready_o),
    .resp_o           (resp_o),
    .resp_v_o         (resp_v_o),
    .resp_ready_i     (resp_ready_i)
`ifdef BP_MEM_ARB_PERF_EN
    ,
    .grant_cnt_o      (grant_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: inputs applied, expected outputs sampled at the falling edge
  typedef struct {
    logic [1:0] cv;
    logic       mr;
    logic       rv;
    logic [1:0] rr;
    logic [1:0] cr;
    logic       mv;
    logic       cid;
    logic       mrr;
    logic [1:0] rvo;
  } vec_t;

  int   n_vec;
  int   n_bad;
  vec_t tbl [14];

  function automatic vec_t mk(input logic [1:0] cv, input logic mr, input logic rv,
                              input logic [1:0] rr, input logic [1:0] cr, input logic mv,
                              input logic cid, input logic mrr, input logic [1:0] rvo);
    vec_t v;
    v.cv = cv; v.mr = mr; v.rv = rv; v.rr = rr;
    v.cr = cr; v.mv = mv; v.cid = cid; v.mrr = mrr; v.rvo = rvo;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string nm);
    logic [W-1:0] exp_cmd;
    logic         ok;
    cmd_v_i         = v.cv;
    mem_cmd_ready_i = v.mr;
    mem_resp_v_i    = v.rv;
    resp_ready_i    = v.rr;
    @(negedge clk);
    exp_cmd = v.cid ? CMD1 : CMD0;
    ok = (cmd_ready_o == v.cr) && (mem_cmd_v_o == v.mv) &&
         (!v.mv || (mem_cmd_o == exp_cmd)) && (mem_resp_ready_o == v.mrr) &&
         (resp_v_o == v.rvo) && (resp_o == RESP);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: cmd_ready=%b want %b, mem_cmd_v=%b want %b, mem_cmd=%h want %h, mem_resp_ready=%b want %b, resp_v=%b want %b, resp=%h want %h",
               nm, cmd_ready_o, v.cr, mem_cmd_v_o, v.mv, mem_cmd_o, exp_cmd,
               mem_resp_ready_o, v.mrr, resp_v_o, v.rvo, resp_o, RESP);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cmd_v_i         = '0;
    mem_cmd_ready_i = 1'b0;
    mem_resp_v_i    = 1'b0;
    resp_ready_i    = '0;
    reset_i         = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    cmd_i = {CMD1, CMD0};
    mem_resp_i = RESP;

    //              cv     mr    rv    rr     cr     mv    cid   mrr   rvo
    tbl[0]  = mk(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    tbl[1]  = mk(2'b11, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00);
    tbl[2]  = mk(2'b11, 1'b1, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00);
    tbl[3]  = mk(2'b11, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00);
    tbl[4]  = mk(2'b11, 1'b1, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00);
    tbl[5]  = mk(2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    tbl[6]  = mk(2'b11, 1'b1, 1'b1, 2'b11, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01);
    tbl[7]  = mk(2'b00, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b10);
    tbl[8]  = mk(2'b00, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01);
    tbl[9]  = mk(2'b00, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10);
    tbl[10] = mk(2'b00, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10);
    tbl[11] = mk(2'b00, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b10);
    tbl[12] = mk(2'b00, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01);
    tbl[13] = mk(2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);

    do_reset();

    // Alternating grants, fill to 4 in flight, pop-and-issue, stalled response
    for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Requester 1 stalls 3 cycles; requester 0 arrives mid-stall but must wait
    do_reset();
    apply(mk(2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00), "lock_c1");
    apply(mk(2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00), "lock_c2");
    apply(mk(2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00), "lock_c3");
    apply(mk(2'b11, 1'b1, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00), "lock_c4_xfer");
    apply(mk(2'b11, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00), "lock_next0");
    apply(mk(2'b01, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00), "prerst_0");

    // Reset with three commands in flight and priority pointing at requester 1
    do_reset();
    apply(mk(2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00), "rst_empty");
    apply(mk(2'b11, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00), "rst_grant0");
    apply(mk(2'b00, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01), "rst_resp0");
    apply(mk(2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00), "rst_drained");

`ifdef BP_MEM_ARB_PERF_EN
    // 10 transfers from requester 0 and 6 from requester 1, one response per cycle
    do_reset();
    n_vec++;
    if (grant_cnt_o != '0) begin
      n_bad++;
      $display("FAIL cnt_reset: grant_cnt=%h want 0", grant_cnt_o);
    end
    begin
      logic g;
      logic prev;
      prev = 1'b0;
      for (int k = 0; k < 16; k++) begin
        g = (k < 12) ? 1'(k % 2) : 1'b0;
        apply(mk((k < 12) ? 2'b11 : 2'b01, 1'b1, (k > 0), 2'b11,
                 g ? 2'b10 : 2'b01, 1'b1, g, (k > 0),
                 (k == 0) ? 2'b00 : (prev ? 2'b10 : 2'b01)),
              $sformatf("cnt_k%0d", k));
        prev = g;
      end
      apply(mk(2'b00, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01), "cnt_last_resp");
    end
    n_vec++;
    if (grant_cnt_o != {32'd6, 32'd10}) begin
      n_bad++;
      $display("FAIL cnt_totals: grant_cnt=%h want %h", grant_cnt_o, {32'd6, 32'd10});
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
